pio_port_bank: RTL and testbench

- Parametrised successor to the fixed 7-bit on-chip processor port.
- Provides PORT_COUNT memory-mapped bidirectional ports, each PORT_WIDTH bits wide, with per-bit implement mask, input synchronisers and edge-detect status with optional interrupt.
- Sits between the CPU-side bus and the external pins. The parent uses `hit` to steer its data-bus mux away from the external bus.

---
 rtl/pio_pkg.sv | 24 ++
 rtl/pio_port.sv | 93 +++++++++
 rtl/pio_port_bank.sv | 65 ++++++
 tb/tb_pio_port_bank.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared constants and helpers for the parametrised processor-port bank.
package pio_pkg;

  localparam logic [1:0] PIO_REG_DDR  = 2'd0;
  localparam logic [1:0] PIO_REG_DATA = 2'd1;
  localparam logic [1:0] PIO_REG_EDGE = 2'd2;
  localparam logic [1:0] PIO_REG_MASK = 2'd3;

  localparam int PIO_MAX_WIDTH = 8;

  // Bits that are both inside the port width and marked implemented.
  function automatic logic [PIO_MAX_WIDTH-1:0] pio_bit_mask(
    input int                       width,
    input logic [PIO_MAX_WIDTH-1:0] impl
  );
    logic [PIO_MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < PIO_MAX_WIDTH; i++) begin
      if (i < width) m[i] = impl[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/pio_port.sv
// One bidirectional port: DDR/DATA latches, 2-flop input synchroniser, pin drivers.
// Edge status and IRQ mask registers exist only when PIO_EDGE_IRQ_EN is defined.
module pio_port
  import pio_pkg::*;
#(
  parameter int                       PORT_WIDTH = 8,
  parameter logic [PIO_MAX_WIDTH-1:0] IMPL_MASK  = 8'hDF
) (
  input  logic                     clock,
  input  logic                     _reset,
  input  logic                     wr_en,
  input  logic [1:0]               reg_sel,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data,
  output logic                     irq_req,
  inout  wire  [PORT_WIDTH-1:0]    pio
);

  localparam logic [PORT_WIDTH-1:0] WMASK =
    PORT_WIDTH'(pio_bit_mask(PORT_WIDTH, IMPL_MASK));

  logic [PORT_WIDTH-1:0] ddr_q;
  logic [PORT_WIDTH-1:0] data_q;
  logic [PORT_WIDTH-1:0] sync1_q;
  logic [PORT_WIDTH-1:0] sync2_q;
  logic [PORT_WIDTH-1:0] wr_bits;
  logic [PORT_WIDTH-1:0] pin_in;
  logic [PORT_WIDTH-1:0] data_view;

  assign wr_bits   = wr_data[PORT_WIDTH-1:0] & WMASK;
  assign pin_in    = pio & WMASK;
  assign data_view = (ddr_q & data_q) | (~ddr_q & sync2_q);

  always_ff @(negedge clock or negedge _reset) begin
    if (!_reset) begin
      ddr_q   <= '0;
      data_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      if (wr_en && reg_sel == PIO_REG_DDR)  ddr_q  <= wr_bits;
      if (wr_en && reg_sel == PIO_REG_DATA) data_q <= wr_bits;
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PIO_EDGE_IRQ_EN
  logic [PORT_WIDTH-1:0] sync3_q;
  logic [PORT_WIDTH-1:0] edge_q;
  logic [PORT_WIDTH-1:0] mask_q;
  logic [PORT_WIDTH-1:0] edge_set;
  logic [PORT_WIDTH-1:0] edge_clr;

  // Only input-direction bits can flag an edge; set beats a same-edge clear.
  assign edge_set = sync2_q & ~sync3_q & ~ddr_q;
  assign edge_clr = (wr_en && reg_sel == PIO_REG_EDGE) ? wr_bits : '0;

  always_ff @(negedge clock or negedge _reset) begin
    if (!_reset) begin
      sync3_q <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
    end else begin
      sync3_q <= sync2_q;
      edge_q  <= (edge_q & ~edge_clr) | edge_set;
      if (wr_en && reg_sel == PIO_REG_MASK) mask_q <= wr_bits;
    end
  end

  assign irq_req = |(edge_q & mask_q);
`else
  assign irq_req = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      PIO_REG_DDR:  rd_data[PORT_WIDTH-1:0] = ddr_q;
      PIO_REG_DATA: rd_data[PORT_WIDTH-1:0] = data_view;
`ifdef PIO_EDGE_IRQ_EN
      PIO_REG_EDGE: rd_data[PORT_WIDTH-1:0] = edge_q;
      PIO_REG_MASK: rd_data[PORT_WIDTH-1:0] = mask_q;
`endif
      default:      rd_data = '0;
    endcase
  end

  for (genvar i = 0; i < PORT_WIDTH; i++) begin : g_pin
    assign pio[i] = ddr_q[i] ? data_q[i] : 1'bz;
  end

endmodule

// File: rtl/pio_port_bank.sv
// Bank of PORT_COUNT memory-mapped ports: address decode, read mux, open-drain _irq.
// _irq can only assert when the design is built with PIO_EDGE_IRQ_EN.
module pio_port_bank
  import pio_pkg::*;
#(
  parameter int                       ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 16'h0000,
  parameter int                       PORT_COUNT = 1,
  parameter int                       PORT_WIDTH = 8,
  parameter logic [PIO_MAX_WIDTH-1:0] IMPL_MASK  = 8'hDF
) (
  input  logic                             clock,
  input  logic                             _reset,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic                             r_w,
  input  logic                             aec,
  input  logic [7:0]                       wr_data,
  output logic [7:0]                       rd_data,
  output logic                             hit,
  inout  wire  [PORT_COUNT*PORT_WIDTH-1:0] pio,
  output wire                              _irq
);

  localparam int WINDOW = 4 * PORT_COUNT;

  // One extra bit keeps addresses below BASE_ADDR from wrapping into the window.
  logic [ADDR_WIDTH:0]   rel;
  logic [1:0]            reg_sel;
  logic [1:0]            port_idx;
  logic                  wr_any;
  logic [7:0]            port_rd [PORT_COUNT];
  logic [PORT_COUNT-1:0] port_irq;

  assign rel      = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign hit      = aec && (rel < (ADDR_WIDTH+1)'(WINDOW));
  assign reg_sel  = rel[1:0];
  assign port_idx = rel[3:2];
  assign wr_any   = hit && !r_w;

  for (genvar n = 0; n < PORT_COUNT; n++) begin : g_port
    pio_port #(
      .PORT_WIDTH (PORT_WIDTH),
      .IMPL_MASK  (IMPL_MASK)
    ) u_port (
      .clock   (clock),
      ._reset  (_reset),
      .wr_en   (wr_any && (port_idx == 2'(n))),
      .reg_sel (reg_sel),
      .wr_data (wr_data),
      .rd_data (port_rd[n]),
      .irq_req (port_irq[n]),
      .pio     (pio[n*PORT_WIDTH +: PORT_WIDTH])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (hit && (port_idx == 2'(i))) rd_data = port_rd[i];
    end
  end

  assign _irq = (|port_irq) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_pio_port_bank.sv
// Self-checking bench for pio_port_bank: two 8-bit ports at the top of the address map.
module tb_pio_port_bank;

  localparam logic [15:0] BASE = 16'hFFF8;
  localparam logic [15:0] IDLE = 16'h1000;

  logic        clock;
  logic        _reset;
  logic [15:0] addr;
  logic        r_w;
  logic        aec;
  logic [7:0]  wr_data;
  wire  [7:0]  rd_data;
  wire         hit;
  wire  [15:0] pio_w;
  wire         irq_n;

  logic [15:0] tb_oe;
  logic [15:0] tb_val;
  int          total;
  int          bad;
  logic [7:0]  exp_q [$];

  for (genvar i = 0; i < 16; i++) begin : g_pin
    assign pio_w[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    pullup pu_pin (pio_w[i]);
  end
  pullup pu_irq (irq_n);

  pio_port_bank #(
    .ADDR_WIDTH (16),
    .BASE_ADDR  (BASE),
    .PORT_COUNT (2),
    .PORT_WIDTH (8),
    .IMPL_MASK  (8'hDF)
  ) dut (
    .clock   (clock),
    ._reset  (_reset),
    .addr    (addr),
    .r_w     (r_w),
    .aec     (aec),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .hit     (hit),
    .pio     (pio_w),
    ._irq    (irq_n)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clock);
    addr = a; r_w = 1'b0; aec = 1'b1; wr_data = d;
    @(negedge clock);
    #1;
    r_w = 1'b1; addr = IDLE; wr_data = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic h);
    @(posedge clock);
    addr = a; r_w = 1'b1; aec = 1'b1;
    #1;
    d = rd_data;
    h = hit;
    #1;
    addr = IDLE;
  endtask

  // Release the bench drivers briefly so undriven pins float up to 1.
  task automatic pin_peek(output logic [15:0] v);
    logic [15:0] keep;
    keep  = tb_oe;
    tb_oe = '0;
    #1;
    v = pio_w;
    tb_oe = keep;
    #1;
  endtask

  task automatic test_reset;
    logic [7:0]  d, e;
    logic        h;
    logic [15:0] pv;
    addr = BASE + 16'd1; aec = 1'b1; r_w = 1'b1;
    #1;
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rst_hit got=%b exp=1", hit); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd got=%h exp=00", rd_data); end
    aec = 1'b0;
    #1;
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL rst_hit_aec got=%b exp=0", hit); end
    pin_peek(pv);
    total++; if (pv !== 16'hFFFF) begin bad++; $display("FAIL rst_pins got=%h exp=ffff", pv); end
    repeat (2) @(negedge clock);
    @(posedge clock);
    _reset = 1'b1;
    for (int r = 0; r < 8; r++) exp_q.push_back(8'h00);
    for (int r = 0; r < 8; r++) begin
      bus_read(BASE + 16'(r), d, h);
      e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL reset_reg%0d got=%h exp=%h", r, d, e); end
    end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL reset_irq got=%b exp=1", irq_n); end
  endtask

  task automatic test_output;
    logic [7:0]  d, e;
    logic        h;
    logic [15:0] pv;
    tb_oe[7:0] = 8'h00;
    bus_write(BASE + 16'd0, 8'hFF);
    bus_write(BASE + 16'd1, 8'hA5);
    exp_q.push_back(8'hDF);
    exp_q.push_back(8'h85);
    bus_read(BASE + 16'd0, d, h);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL out_ddr0 got=%h exp=%h", d, e); end
    bus_read(BASE + 16'd1, d, h);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL out_data0 got=%h exp=%h", d, e); end
    pin_peek(pv);
    total++; if (pv !== 16'hFFA5) begin bad++; $display("FAIL out_pins0 got=%h exp=ffa5", pv); end
    tb_oe[15:8] = 8'hF0;
    bus_write(BASE + 16'd4, 8'h0F);
    bus_write(BASE + 16'd5, 8'h3C);
    repeat (3) @(negedge clock);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h0C);
    bus_read(BASE + 16'd4, d, h);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL out_ddr1 got=%h exp=%h", d, e); end
    bus_read(BASE + 16'd5, d, h);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL out_data1 got=%h exp=%h", d, e); end
    pin_peek(pv);
    total++; if (pv !== 16'hFCA5) begin bad++; $display("FAIL out_pins1 got=%h exp=fca5", pv); end
  endtask

  task automatic test_sync;
    logic [7:0] d, e;
    logic       h;
    bus_write(BASE + 16'd0, 8'h00);
    tb_oe[7:0]  = 8'hFF;
    tb_val[7:0] = 8'h00;
    repeat (4) @(negedge clock);
    #1;
    tb_val[7:0] = 8'h0F;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h0F);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      bus_read(BASE + 16'd1, d, h);
      e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL sync_edge%0d got=%h exp=%h", k, d, e); end
    end
  endtask

`ifdef PIO_EDGE_IRQ_EN
  task automatic test_edge;
    logic [7:0] d, e;
    logic       h;
    tb_val[7:0] = 8'h00;
    repeat (4) @(negedge clock);
    bus_write(BASE + 16'd2, 8'hFF);
    bus_write(BASE + 16'd6, 8'hFF);
    bus_write(BASE + 16'd7, 8'hFF);
    exp_q.push_back(8'hDF);
    bus_read(BASE + 16'd7, d, h);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL mask1_rd got=%h exp=%h", d, e); end
    bus_write(BASE + 16'd7, 8'h00);
    bus_write(BASE + 16'd3, 8'h01);
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL edge_idle_irq got=%b exp=1", irq_n); end
    @(negedge clock);
    #1;
    tb_val[0] = 1'b1;
    for (int k = 1; k <= 3; k++) exp_q.push_back((k == 3) ? 8'h01 : 8'h00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      bus_read(BASE + 16'd2, d, h);
      e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL edge_n%0d got=%h exp=%h", k, d, e); end
      total++;
      if (irq_n !== ((k == 3) ? 1'b0 : 1'b1)) begin
        bad++; $display("FAIL edge_irq_n%0d got=%b exp=%b", k, irq_n, (k == 3) ? 1'b0 : 1'b1);
      end
    end
    bus_write(BASE + 16'd2, 8'h01);
    exp_q.push_back(8'h00);
    bus_read(BASE + 16'd2, d, h);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL edge_w1c got=%h exp=%h", d, e); end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL edge_w1c_irq got=%b exp=1", irq_n); end
    tb_val[0] = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    tb_val[0] = 1'b1;
    repeat (2) @(negedge clock);
    bus_write(BASE + 16'd2, 8'h01);
    exp_q.push_back(8'h01);
    bus_read(BASE + 16'd2, d, h);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL edge_set_wins got=%h exp=%h", d, e); end
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL edge_set_wins_irq got=%b exp=0", irq_n); end
    bus_write(BASE + 16'd2, 8'h01);
    bus_write(BASE + 16'd3, 8'h00);
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL edge_final_irq got=%b exp=1", irq_n); end
  endtask
`else
  task automatic test_no_edge;
    logic [7:0]  d, e;
    logic        h;
    logic [15:0] offs [4];
    offs[0] = 16'd2; offs[1] = 16'd3; offs[2] = 16'd6; offs[3] = 16'd7;
    for (int k = 0; k < 4; k++) bus_write(BASE + offs[k], 8'hFF);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
    for (int k = 0; k < 4; k++) begin
      bus_read(BASE + offs[k], d, h);
      e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL noedge_rd%0d got=%h exp=%h", k, d, e); end
      total++; if (h !== 1'b1) begin bad++; $display("FAIL noedge_hit%0d got=%b exp=1", k, h); end
    end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL noedge_irq got=%b exp=1", irq_n); end
  endtask
`endif

  task automatic test_decode;
    logic [7:0]  d, e;
    logic        h;
    logic [15:0] outside [2];
    @(posedge clock);
    addr = BASE; r_w = 1'b0; aec = 1'b0; wr_data = 8'hFF;
    #1;
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL aec_hit got=%b exp=0", hit); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL aec_rd got=%h exp=00", rd_data); end
    @(negedge clock);
    #1;
    r_w = 1'b1; aec = 1'b1; addr = IDLE;
    outside[0] = BASE + 16'd8;
    outside[1] = BASE - 16'd1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      addr = outside[k]; r_w = 1'b0; wr_data = 8'hFF;
      #1;
      total++; if (hit !== 1'b0) begin bad++; $display("FAIL window_hit%0d got=%b exp=0", k, hit); end
      @(negedge clock);
      #1;
      r_w = 1'b1; addr = IDLE;
    end
    bus_read(BASE + 16'd7, d, h);
    total++; if (h !== 1'b1) begin bad++; $display("FAIL top_hit got=%b exp=1", h); end
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h0F);
    bus_read(BASE + 16'd0, d, h);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL decode_ddr0 got=%h exp=%h", d, e); end
    bus_read(BASE + 16'd4, d, h);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL decode_ddr1 got=%h exp=%h", d, e); end
  endtask

  task automatic test_reset_mid_write;
    logic [7:0]  d, e;
    logic        h;
    logic [15:0] pv;
    tb_oe[7:0] = 8'h00;
    bus_write(BASE + 16'd0, 8'hFF);
    bus_write(BASE + 16'd1, 8'h5A);
    pin_peek(pv);
    total++; if (pv !== 16'hFC7A) begin bad++; $display("FAIL pre_rst_pins got=%h exp=fc7a", pv); end
    @(posedge clock);
    addr = BASE + 16'd1; r_w = 1'b0; aec = 1'b1; wr_data = 8'hFF;
    #2;
    _reset = 1'b0;
    pin_peek(pv);
    total++; if (pv !== 16'hFFFF) begin bad++; $display("FAIL midrst_pins got=%h exp=ffff", pv); end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL midrst_hit got=%b exp=1", hit); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL midrst_rd got=%h exp=00", rd_data); end
    @(negedge clock);
    #1;
    r_w = 1'b1; addr = IDLE;
    tb_oe = 16'hFFFF; tb_val = 16'h0000;
    @(posedge clock);
    _reset = 1'b1;
    for (int r = 0; r < 8; r++) exp_q.push_back(8'h00);
    for (int r = 0; r < 8; r++) begin
      bus_read(BASE + 16'(r), d, h);
      e = exp_q.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL postrst_reg%0d got=%h exp=%h", r, d, e); end
    end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL postrst_irq got=%b exp=1", irq_n); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    _reset  = 1'b0;
    addr    = IDLE;
    r_w     = 1'b1;
    aec     = 1'b0;
    wr_data = 8'h00;
    tb_oe   = 16'hFFFF;
    tb_val  = 16'h0000;
    test_reset();
    test_output();
    test_sync();
`ifdef PIO_EDGE_IRQ_EN
    test_edge();
`else
    test_no_edge();
`endif
    test_decode();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
